// File: rtl/bbus_pkg.sv
// bbus_pkg: B-bus select codes, sequencer states and window geometry
package bbus_pkg;
  localparam int NUM_TAPS = 9;
  localparam int SEL_W = 5;
  localparam logic [SEL_W-1:0] SEL_NONE = 5'b00000;
  localparam logic [SEL_W-1:0] SEL_MDR = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_K0 = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_K1 = 5'b00011;
  localparam logic [SEL_W-1:0] SEL_K2 = 5'b00100;
  localparam logic [SEL_W-1:0] SEL_K3 = 5'b00101;
  localparam logic [SEL_W-1:0] SEL_K4 = 5'b00110;
  localparam logic [SEL_W-1:0] SEL_K5 = 5'b00111;
  localparam logic [SEL_W-1:0] SEL_K6 = 5'b01000;
  localparam logic [SEL_W-1:0] SEL_K7 = 5'b01001;
  localparam logic [SEL_W-1:0] SEL_K8 = 5'b01010;
  localparam logic [SEL_W-1:0] SEL_P1 = 5'b01011;
  localparam logic [SEL_W-1:0] SEL_P2 = 5'b01100;
  localparam logic [SEL_W-1:0] SEL_P3 = 5'b01101;
  localparam logic [SEL_W-1:0] SEL_DP = 5'b01110;
  localparam logic [SEL_W-1:0] SEL_CV = 5'b01111;
  localparam logic [SEL_W-1:0] SEL_I = 5'b10000;
  localparam logic [SEL_W-1:0] SEL_MBRU = 5'b10001;
  localparam logic [SEL_W-1:0] SEL_PC = 5'b10011;
  localparam logic [SEL_W-1:0] SEL_MAR = 5'b10111;
  typedef enum logic [2:0] {IDLE, SEL_K, SEL_P, MAC_WAIT, DONE} state_e;
endpackage

// File: rtl/bbus_conv_sequencer_if.sv
// bbus_conv_sequencer_if: CU, B-bus mux and MAC handshake signals of the sequencer
interface bbus_conv_sequencer_if;
  import bbus_pkg::*;
  logic start, abort, cu_req, cu_gnt;
  logic [SEL_W-1:0] cu_sel, bus_sel;
  logic ld_k, ld_p, acc_clr, mac_valid, mac_ready, busy, done, err;
  logic [1:0] pix_col;
  logic [3:0] tap_idx;
  modport master(
    output start, abort, cu_req, cu_sel, mac_ready,
    input cu_gnt, bus_sel, ld_k, ld_p, pix_col, tap_idx, acc_clr, mac_valid, busy, done, err
  );
  modport slave(
    input start, abort, cu_req, cu_sel, mac_ready,
    output cu_gnt, bus_sel, ld_k, ld_p, pix_col, tap_idx, acc_clr, mac_valid, busy, done, err
  );
endinterface

// File: rtl/bbus_tap_decode.sv
// bbus_tap_decode: maps a kernel tap to its K code, pixel row code and column
module bbus_tap_decode
  import bbus_pkg::*;
(
  input  logic [3:0]       tap,
  output logic [SEL_W-1:0] k_code,
  output logic [SEL_W-1:0] p_code,
  output logic [1:0]       col
);
  logic [1:0] row;
  // row = tap/3, col = tap%3 without a divider
  always_comb begin
    row = tap < 4'd3 ? 2'd0 : tap < 4'd6 ? 2'd1 : 2'd2;
    col = 2'(tap - 4'(row) * 4'd3);
    k_code = SEL_K0 + SEL_W'(tap);
    p_code = SEL_P1 + SEL_W'(row);
  end
endmodule

// File: rtl/bbus_conv_sequencer.sv
// bbus_conv_sequencer: walks a 3x3 kernel over the B-bus and handshakes each product with the MAC
module bbus_conv_sequencer
  import bbus_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input logic clk,
  input logic rst_n,
  bbus_conv_sequencer_if.slave bif
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [3:0] LAST = 4'(NUM_TAPS - 1);
  state_e state_q, state_d;
  logic [3:0] tap_idx_q, tap_idx_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic err_q, err_d;
  logic gnt;
  logic [SEL_W-1:0] k_code, p_code;
  logic [1:0] col;
  bbus_tap_decode u_dec (.tap(tap_idx_q), .k_code(k_code), .p_code(p_code), .col(col));
  // state and window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_idx_q <= '0;
      wait_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_idx_q <= tap_idx_d;
      wait_cnt_q <= wait_cnt_d;
      err_q <= err_d;
    end
  end
  // next state: start only from IDLE, abort beats mac_ready, timeout drops back to IDLE with err
  always_comb begin
    state_d = state_q;
    tap_idx_d = tap_idx_q;
    wait_cnt_d = wait_cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      if (bif.start) begin
        state_d = SEL_K;
        tap_idx_d = '0;
        wait_cnt_d = '0;
        err_d = 1'b0;
      end
    end else if (bif.abort) begin
      state_d = IDLE;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        SEL_K: state_d = SEL_P;
        SEL_P: state_d = MAC_WAIT;
        MAC_WAIT:
          if (bif.mac_ready) begin
            wait_cnt_d = '0;
            state_d = tap_idx_q == LAST ? DONE : SEL_K;
            tap_idx_d = tap_idx_q == LAST ? tap_idx_q : tap_idx_q + 4'd1;
          end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
            wait_cnt_d = '0;
            state_d = IDLE;
            err_d = 1'b1;
          end else
            wait_cnt_d = wait_cnt_q + CW'(1);
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs decoded from state; only the IDLE grant path sees inputs
  always_comb begin
    gnt = state_q == IDLE && bif.cu_req && !bif.start;
    bif.cu_gnt = gnt;
    bif.busy = state_q != IDLE;
    bif.ld_k = state_q == SEL_K;
    bif.acc_clr = state_q == SEL_K && tap_idx_q == 4'd0;
    bif.ld_p = state_q == SEL_P;
    bif.mac_valid = state_q == MAC_WAIT;
    bif.done = state_q == DONE;
    bif.err = err_q;
    bif.tap_idx = tap_idx_q;
    bif.pix_col = (state_q == SEL_P || state_q == MAC_WAIT) ? col : 2'd0;
    bif.bus_sel = state_q == SEL_K ? k_code :
                  (state_q == SEL_P || state_q == MAC_WAIT) ? p_code :
                  gnt ? bif.cu_sel : SEL_NONE;
  end
endmodule
